stream_to_1d_array: RTL and testbench
=====================================

# stream_to_1d_array

Accumulates a valid/ready stream of BIT_WIDTH-bit elements into one packed COLS*BIT_WIDTH vector and presents it on a valid/ready output. It sits directly upstream of the 1D-to-2D array conversion stage: its out_data drives that stage's packed input unchanged. The first element received in a vector lands in column 0, bits [BIT_WIDTH-1:0]. The next lands in column 1, and so on.

## Interface
- BIT_WIDTH, 4, bits per element/column.
- COLS, 8, elements per packed vector; legal range COLS >= 2.
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  BIT_WIDTH  element.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts in_data this cycle.
- out_data  output  COLS*BIT_WIDTH  packed vector; column i at bits [i*BIT_WIDTH +: BIT_WIDTH].
- out_valid  output  1  out_data holds a complete vector.
- out_ready  input  1  downstream consumes out_data this cycle.
- flush  input  1  only with STREAM_TO_1D_ARRAY_FLUSH_EN; emit partial vector.
- out_cols  output  $clog2(COLS+1)  only with STREAM_TO_1D_ARRAY_FLUSH_EN; number of valid columns in out_data.

## Operation
- State:
  - cnt: 0..COLS, columns filled.
  - fill_buf: COLS*BIT_WIDTH.
  - out_buf: drives out_data.
  - out_valid register.
- Transfer rules:
  - Input accept: in_valid && in_ready.
  - Output transfer: out_valid && out_ready.
  - slot_free = !out_valid || out_ready.
- in_ready = (cnt != COLS), combinational from cnt only; never depends on in_valid.
- Accept with cnt < COLS-1: column cnt of fill_buf <= in_data; cnt <= cnt+1.
- Accept with cnt == COLS-1, i.e. the vector is completed:
  - If slot_free: out_buf <= fill_buf with in_data merged into column COLS-1; out_valid <= 1; fill_buf <= 0; cnt <= 0.
  - Otherwise: merge into fill_buf; cnt <= COLS, which is the held state.
- cnt == COLS and slot_free: out_buf <= fill_buf; out_valid <= 1; fill_buf <= 0; cnt <= 0.
- Output transfer with no new vector loaded that cycle: out_valid <= 0. out_buf keeps its value.
- Simultaneous output transfer and vector completion: the new vector replaces the old one and out_valid stays 1. There is no bubble.
- Columns not yet written read as 0, because fill_buf is cleared on every move to out_buf.
- out_data is stable while out_valid && !out_ready.
- Reset, asynchronous, also when asserted mid-vector:
  - cnt = 0, fill_buf = 0, out_buf = 0, out_valid = 0, so in_ready = 1.
  - Any partial or pending vector is discarded.

## Timing
- Latency: the last element is accepted at edge t, and out_valid = 1 with the full vector after edge t.
- Throughput: sustained 1 element/cycle while out_ready is held high. in_ready never drops in that case.
- Backpressure: with out_valid held and not consumed, the block accepts exactly COLS further elements, then in_ready = 0. in_ready returns to 1 the cycle after the output transfer.
- All outputs are registered, except in_ready, which is a decode of the registered cnt.

## Configuration
- STREAM_TO_1D_ARRAY_FLUSH_EN defined: adds the flush and out_cols ports.
  - flush sampled with 0 < cnt' < COLS completes the vector early, where cnt' is cnt after any same-cycle accept. The unused columns are zero.
  - The partial vector uses the same slot_free and held-state rules as a full vector.
  - out_cols = columns filled, and equals COLS for a normal vector.
  - flush with cnt' == 0 or cnt' == COLS is ignored.
  - A same-cycle accept is included in the flushed vector.
  - out_cols resets to 0.
- Undefined: no flush or out_cols ports; only full vectors are emitted.

## Structure
- The shared package holds:
  - The localparam for the cnt width, $clog2(COLS+1).
  - A function returning the column bit offset, i*BIT_WIDTH.
- One sub-module is natural: column_insert, a combinational block that writes in_data into column index idx of a packed vector. The block uses it for both the fill_buf update and the completion merge.

## Test plan
- Reset then feed 1,2,...,8 with out_ready = 1 -> out_data = 32'h87654321, out_valid high for exactly 1 cycle, 1 cycle after the 8th accept.
- Feed 16 consecutive elements 0..F with out_ready = 1 -> vectors 32'h76543210 then 32'hFEDCBA98, in_ready constantly 1.
- Hold out_ready = 0 after the first vector and keep in_valid high -> 8 more accepts, then in_ready = 0. out_data is held at the first vector. Pulse out_ready -> second vector appears on the next cycle and in_ready = 1.
- Assert rst_n = 0 after 3 elements, release, then feed 8 elements A..H (4'hA,4'hB,...) -> only those 8 form the first vector; no leftover columns.
- With STREAM_TO_1D_ARRAY_FLUSH_EN: feed 5,6,7 then flush -> out_data = 32'h00000765, out_cols = 3.
- With STREAM_TO_1D_ARRAY_FLUSH_EN: flush with cnt = 0 -> no output.

Source files
------------

// File: rtl/stream_to_1d_array_pkg.sv
// Shared sizing and column addressing for the stream-to-packed-vector path.
// Everything that needs the element width or the column count imports this package.
package stream_to_1d_array_pkg;

    localparam int BIT_WIDTH = 4;
    localparam int COLS      = 8;
    localparam int OUT_W     = COLS * BIT_WIDTH;
    localparam int CNT_W     = $clog2(COLS + 1);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(COLS);

    function automatic int col_offset(input int i);
        return i * BIT_WIDTH;
    endfunction

endpackage

// File: rtl/stream_to_1d_array_if.sv
// Element-in / packed-vector-out handshake bundle; slave is the converter's view.
// flush/out_cols exist only with STREAM_TO_1D_ARRAY_FLUSH_EN.
interface stream_to_1d_array_if
    import stream_to_1d_array_pkg::*;
();

    logic [BIT_WIDTH-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [OUT_W-1:0]     out_data;
    logic                 out_valid;
    logic                 out_ready;
`ifdef STREAM_TO_1D_ARRAY_FLUSH_EN
    logic                 flush;
    logic [CNT_W-1:0]     out_cols;
`endif

    modport slave (
        input  in_data, in_valid, out_ready,
`ifdef STREAM_TO_1D_ARRAY_FLUSH_EN
        input  flush,
        output out_cols,
`endif
        output in_ready, out_data, out_valid
    );

    modport master (
        output in_data, in_valid, out_ready,
`ifdef STREAM_TO_1D_ARRAY_FLUSH_EN
        output flush,
        input  out_cols,
`endif
        input  in_ready, out_data, out_valid
    );

endinterface

// File: rtl/stream_to_1d_array_column_insert.sv
// Purpose: writes one element into column i_idx of a packed vector.
// Latency: combinational. Backpressure: none; an out-of-range index leaves the vector unchanged.
module stream_to_1d_array_column_insert
    import stream_to_1d_array_pkg::*;
(
    input  logic [OUT_W-1:0]     i_vec,
    input  logic [CNT_W-1:0]     i_idx,
    input  logic [BIT_WIDTH-1:0] i_data,
    output logic [OUT_W-1:0]     o_vec
);

    always_comb begin
        o_vec = i_vec;
        for (int c = 0; c < COLS; c++) begin
            if (i_idx == CNT_W'(c)) begin
                o_vec[col_offset(c) +: BIT_WIDTH] = i_data;
            end
        end
    end

endmodule

// File: rtl/stream_to_1d_array.sv
// Purpose: packs COLS stream elements into one vector (column 0 first); STREAM_TO_1D_ARRAY_FLUSH_EN adds early flush.
// Latency: out_valid rises the cycle after the last element is accepted.
// Backpressure: holds one finished vector behind the output register, then drops in_ready until a slot frees.
module stream_to_1d_array
    import stream_to_1d_array_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    stream_to_1d_array_if.slave  bus
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_acc;
    logic [OUT_W-1:0] r_fill_buf;
    logic [OUT_W-1:0] w_fill_nxt;
    logic [OUT_W-1:0] w_fill_acc;
    logic [OUT_W-1:0] w_merged;
    logic [OUT_W-1:0] r_out_buf;
    logic [OUT_W-1:0] w_out_buf_nxt;
    logic             r_out_valid;
    logic             w_out_valid_nxt;
    logic             w_accept;
    logic             w_slot_free;
    logic             w_complete;
`ifdef STREAM_TO_1D_ARRAY_FLUSH_EN
    logic [CNT_W-1:0] r_out_cols;
    logic [CNT_W-1:0] w_out_cols_nxt;
    logic [CNT_W-1:0] r_held_cols;
    logic [CNT_W-1:0] w_held_cols_nxt;
`endif

    assign bus.in_ready  = (r_cnt != CNT_FULL);
    assign bus.out_data  = r_out_buf;
    assign bus.out_valid = r_out_valid;
`ifdef STREAM_TO_1D_ARRAY_FLUSH_EN
    assign bus.out_cols  = r_out_cols;
`endif

    assign w_accept    = bus.in_valid && bus.in_ready;
    assign w_slot_free = !r_out_valid || bus.out_ready;
    assign w_cnt_acc   = w_accept ? (r_cnt + CNT_W'(1)) : r_cnt;
    assign w_fill_acc  = w_accept ? w_merged : r_fill_buf;

    // A held vector (cnt == COLS) never accepts, so idx == COLS matches no column.
    stream_to_1d_array_column_insert u_column_insert (
        .i_vec  (r_fill_buf),
        .i_idx  (r_cnt),
        .i_data (bus.in_data),
        .o_vec  (w_merged)
    );

`ifdef STREAM_TO_1D_ARRAY_FLUSH_EN
    assign w_complete = (w_cnt_acc == CNT_FULL) ||
                        (bus.flush && (w_cnt_acc != '0) && (w_cnt_acc != CNT_FULL));
`else
    assign w_complete = (w_cnt_acc == CNT_FULL);
`endif

    always_comb begin
        w_cnt_nxt       = w_cnt_acc;
        w_fill_nxt      = w_fill_acc;
        w_out_buf_nxt   = r_out_buf;
        w_out_valid_nxt = r_out_valid && !bus.out_ready;
`ifdef STREAM_TO_1D_ARRAY_FLUSH_EN
        w_out_cols_nxt  = r_out_cols;
        w_held_cols_nxt = r_held_cols;
`endif
        if (r_cnt == CNT_FULL) begin
            if (w_slot_free) begin
                w_out_buf_nxt   = r_fill_buf;
                w_out_valid_nxt = 1'b1;
                w_fill_nxt      = '0;
                w_cnt_nxt       = '0;
`ifdef STREAM_TO_1D_ARRAY_FLUSH_EN
                w_out_cols_nxt  = r_held_cols;
`endif
            end
        end else if (w_complete) begin
            if (w_slot_free) begin
                w_out_buf_nxt   = w_fill_acc;
                w_out_valid_nxt = 1'b1;
                w_fill_nxt      = '0;
                w_cnt_nxt       = '0;
`ifdef STREAM_TO_1D_ARRAY_FLUSH_EN
                w_out_cols_nxt  = w_cnt_acc;
`endif
            end else begin
                // Park in the held state; a short flushed vector remembers its real width.
                w_cnt_nxt       = CNT_FULL;
`ifdef STREAM_TO_1D_ARRAY_FLUSH_EN
                w_held_cols_nxt = w_cnt_acc;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_fill_buf  <= '0;
            r_out_buf   <= '0;
            r_out_valid <= 1'b0;
`ifdef STREAM_TO_1D_ARRAY_FLUSH_EN
            r_out_cols  <= '0;
            r_held_cols <= '0;
`endif
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_fill_buf  <= w_fill_nxt;
            r_out_buf   <= w_out_buf_nxt;
            r_out_valid <= w_out_valid_nxt;
`ifdef STREAM_TO_1D_ARRAY_FLUSH_EN
            r_out_cols  <= w_out_cols_nxt;
            r_held_cols <= w_held_cols_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_stream_to_1d_array.sv
// Directed scenarios followed by randomized traffic checked against a vector-queue scoreboard.
// Flush scenarios are compiled in with STREAM_TO_1D_ARRAY_FLUSH_EN.
module tb_stream_to_1d_array;
    import stream_to_1d_array_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    stream_to_1d_array_if bus();

    stream_to_1d_array dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [BIT_WIDTH-1:0] d, input logic ordy);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    logic [OUT_W-1:0] exp_q[$];
    logic [OUT_W-1:0] acc_vec;
    logic [OUT_W-1:0] hold_dat;
    logic [OUT_W-1:0] exp_vec;
    int               acc_n;
    int               drops;
    logic             hold;
    logic             acc;
    logic             xfer;

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
`ifdef STREAM_TO_1D_ARRAY_FLUSH_EN
        bus.flush     = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 64'(bus.in_ready), 64'(1));
        check("reset_out_valid", 64'(bus.out_valid), 64'(0));
        check("reset_out_data", 64'(bus.out_data), 64'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1..8 with downstream ready: one-cycle valid pulse
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, BIT_WIDTH'(i), 1'b1);
            if (i == 7) check("t1_not_early", 64'(bus.out_valid), 64'(0));
        end
        check("t1_valid", 64'(bus.out_valid), 64'(1));
        check("t1_data", 64'(bus.out_data), 64'(32'h87654321));
        drive(1'b0, '0, 1'b1);
        check("t1_single_cycle", 64'(bus.out_valid), 64'(0));

        // 16 back-to-back elements, no in_ready drop
        drops = 0;
        for (int i = 0; i < 16; i++) begin
            if (!bus.in_ready) drops++;
            drive(1'b1, BIT_WIDTH'(i), 1'b1);
            if (i == 7) check("t2_vec0", 64'(bus.out_data), 64'(32'h76543210));
            if (i == 15) check("t2_vec1", 64'(bus.out_data), 64'(32'hFEDCBA98));
        end
        check("t2_in_ready_drops", 64'(drops), 64'(0));
        drive(1'b0, '0, 1'b1);

        // Backpressure: one vector in output, one held, then stall
        drops = 0;
        for (int i = 0; i < 16; i++) begin
            if (!bus.in_ready) drops++;
            drive(1'b1, BIT_WIDTH'(i), 1'b0);
        end
        check("t3_accepts", 64'(drops), 64'(0));
        check("t3_stalled", 64'(bus.in_ready), 64'(0));
        check("t3_held_data", 64'(bus.out_data), 64'(32'h76543210));
        drive(1'b1, 4'h5, 1'b0);
        drive(1'b1, 4'h5, 1'b0);
        check("t3_still_stalled", 64'(bus.in_ready), 64'(0));
        check("t3_still_held", 64'(bus.out_data), 64'(32'h76543210));
        check("t3_still_valid", 64'(bus.out_valid), 64'(1));
        drive(1'b0, '0, 1'b1);
        check("t3_second_vec", 64'(bus.out_data), 64'(32'hFEDCBA98));
        check("t3_second_valid", 64'(bus.out_valid), 64'(1));
        check("t3_ready_back", 64'(bus.in_ready), 64'(1));
        drive(1'b0, '0, 1'b1);
        check("t3_drained", 64'(bus.out_valid), 64'(0));

        // Async reset mid-vector discards the partial columns
        drive(1'b1, 4'h1, 1'b1);
        drive(1'b1, 4'h2, 1'b1);
        drive(1'b1, 4'h3, 1'b1);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("t4_rst_in_ready", 64'(bus.in_ready), 64'(1));
        check("t4_rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("t4_rst_out_data", 64'(bus.out_data), 64'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(1'b1, 4'hA, 1'b1);
        drive(1'b1, 4'hB, 1'b1);
        drive(1'b1, 4'hC, 1'b1);
        drive(1'b1, 4'hD, 1'b1);
        drive(1'b1, 4'hE, 1'b1);
        drive(1'b1, 4'hF, 1'b1);
        drive(1'b1, 4'h1, 1'b1);
        drive(1'b1, 4'h2, 1'b1);
        check("t4_valid", 64'(bus.out_valid), 64'(1));
        check("t4_data", 64'(bus.out_data), 64'(32'h21FEDCBA));
        drive(1'b0, '0, 1'b1);

`ifdef STREAM_TO_1D_ARRAY_FLUSH_EN
        drive(1'b1, 4'h5, 1'b1);
        drive(1'b1, 4'h6, 1'b1);
        drive(1'b1, 4'h7, 1'b1);
        bus.flush = 1'b1;
        drive(1'b0, '0, 1'b0);
        bus.flush = 1'b0;
        check("f1_valid", 64'(bus.out_valid), 64'(1));
        check("f1_data", 64'(bus.out_data), 64'(32'h00000765));
        check("f1_cols", 64'(bus.out_cols), 64'(3));
        drive(1'b0, '0, 1'b1);
        check("f1_drained", 64'(bus.out_valid), 64'(0));
        bus.flush = 1'b1;
        drive(1'b0, '0, 1'b1);
        bus.flush = 1'b0;
        check("f2_empty_flush", 64'(bus.out_valid), 64'(0));
        drive(1'b1, 4'h1, 1'b1);
        drive(1'b1, 4'h2, 1'b1);
        bus.flush = 1'b1;
        drive(1'b1, 4'h3, 1'b1);
        bus.flush = 1'b0;
        check("f3_data", 64'(bus.out_data), 64'(32'h00000321));
        check("f3_cols", 64'(bus.out_cols), 64'(3));
        drive(1'b0, '0, 1'b1);
        for (int i = 0; i < COLS; i++) drive(1'b1, 4'h9, 1'b1);
        check("f4_full_cols", 64'(bus.out_cols), 64'(COLS));
        drive(1'b0, '0, 1'b1);
`endif

        // Randomized traffic against a vector-queue scoreboard
        exp_q.delete();
        acc_vec = '0;
        acc_n   = 0;
        hold    = 1'b0;
        hold_dat = '0;
        for (int c = 0; c < 620; c++) begin
            bus.in_valid  = (c < 600) ? ($urandom_range(0, 9) < 7) : 1'b0;
            bus.out_ready = (c < 600) ? ($urandom_range(0, 9) < 6) : 1'b1;
            bus.in_data   = BIT_WIDTH'($urandom);
            check("rnd_in_ready", 64'(bus.in_ready), 64'(exp_q.size() < 2));
            check("rnd_out_valid", 64'(bus.out_valid), 64'(exp_q.size() > 0));
            if (hold) check("rnd_stable", 64'(bus.out_data), 64'(hold_dat));
            acc  = bus.in_valid && bus.in_ready;
            xfer = bus.out_valid && bus.out_ready;
            hold = bus.out_valid && !bus.out_ready;
            hold_dat = bus.out_data;
            if (xfer && exp_q.size() > 0) begin
                exp_vec = exp_q.pop_front();
                check("rnd_vec", 64'(bus.out_data), 64'(exp_vec));
            end
            if (acc) begin
                acc_vec[acc_n*BIT_WIDTH +: BIT_WIDTH] = bus.in_data;
                acc_n++;
                if (acc_n == COLS) begin
                    exp_q.push_back(acc_vec);
                    acc_vec = '0;
                    acc_n   = 0;
                end
            end
            @(posedge clk);
            #1;
        end
        check("rnd_all_delivered", 64'(exp_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
